// File: rtl/ws2812_pkg.sv
// Shared types and timing helpers for the WS2812 frame controller and serializer.
package ws2812_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, SCALE, SEND, DRAIN, LATCH} state_t;

    localparam int PIX_W = 24;
    localparam int CH_W  = 8;
    localparam int G_LSB = 16;
    localparam int R_LSB = 8;
    localparam int B_LSB = 0;

    localparam int T0H_NS = 400;
    localparam int T0L_NS = 850;
    localparam int T1H_NS = 800;
    localparam int T1L_NS = 450;

    function automatic int ns_to_cycles(input int clk_fre, input int ns);
        return (clk_fre / 1000) * ns / 1_000_000;
    endfunction

    function automatic int reset_cycles(input int clk_fre, input int reset_us);
        return clk_fre / 1_000_000 * reset_us;
    endfunction

endpackage

// File: rtl/ws2812_frame_ctrl_if.sv
// Pixel stream between the frame controller and the bit serializer.
interface ws2812_frame_ctrl_if;
    import ws2812_pkg::*;

    logic             pix_valid;
    logic [PIX_W-1:0] pix_data;
    logic             pix_ready;
    logic             tx_idle;

    modport master (output pix_valid, output pix_data, input pix_ready, input tx_idle);
    modport slave  (input pix_valid, input pix_data, output pix_ready, output tx_idle);
endinterface

// File: rtl/ws2812_pix_ram.sv
// Pixel buffer: one write and one registered read per cycle, read returns old data on collision.
module ws2812_pix_ram
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS = 8,
    parameter int ADDR_W   = 3
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [PIX_W-1:0]  rd_data
);

    logic [PIX_W-1:0] mem [NUM_LEDS];

    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_addr) < 32'(NUM_LEDS)))
            mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/ws2812_frame_ctrl.sv
// Frame scheduler: streams the brightness-scaled pixel buffer to the serializer, then holds the latch gap.
module ws2812_frame_ctrl
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS   = 8,
    parameter int CLK_FRE    = 27_000_000,
    parameter int RESET_US   = 80,
    parameter int REFRESH_HZ = 0,
    parameter int ADDR_W     = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [PIX_W-1:0]      wr_data,
    input  logic [CH_W-1:0]       bright,
    input  logic                  frame_req,
    output logic                  busy,
    output logic                  frame_done,
    ws2812_frame_ctrl_if.master   pix
);

    localparam int RESET_CYCLES   = reset_cycles(CLK_FRE, RESET_US);
    localparam int REFRESH_PERIOD = CLK_FRE / ((REFRESH_HZ > 0) ? REFRESH_HZ : 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_LEDS - 1);

    // Brightness uses (b+1) so that 255 is an exact pass-through.
    function automatic logic [CH_W-1:0] scale_ch(input logic [CH_W-1:0] c, input logic [CH_W-1:0] b);
        logic [15:0] prod;
        prod = {8'd0, c} * ({8'd0, b} + 16'd1);
        return prod[15:8];
    endfunction

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [CH_W-1:0]   bright_q, bright_d;
    logic [31:0]       gap_q, gap_d;
    logic [31:0]       refresh_cnt_q;
    logic              pending_q, pending_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              vld_q, vld_d;
    logic [PIX_W-1:0]  data_q, data_d;
    logic [PIX_W-1:0]  rd_data_p1;
    logic              tick;
    logic              start_req;

    ws2812_pix_ram #(.NUM_LEDS(NUM_LEDS), .ADDR_W(ADDR_W)) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (idx_q),
        .rd_data (rd_data_p1)
    );

    always_ff @(posedge clk) begin
        if (rst)
            refresh_cnt_q <= '0;
        else if (REFRESH_HZ > 0)
            refresh_cnt_q <= tick ? '0 : refresh_cnt_q + 32'd1;
    end

    assign tick      = (REFRESH_HZ > 0) && (refresh_cnt_q == 32'(REFRESH_PERIOD - 1));
    assign start_req = frame_req | tick;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        bright_d  = bright_q;
        gap_d     = gap_q;
        pending_d = pending_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        vld_d     = vld_q;
        data_d    = data_q;
        case (state_q)
            IDLE: if (start_req || pending_q) begin
                state_d   = LOAD;
                bright_d  = bright;
                idx_d     = '0;
                pending_d = 1'b0;
                busy_d    = 1'b1;
            end
            LOAD:  state_d = SCALE;
            SCALE: begin
                data_d[G_LSB +: CH_W] = scale_ch(rd_data_p1[G_LSB +: CH_W], bright_q);
                data_d[R_LSB +: CH_W] = scale_ch(rd_data_p1[R_LSB +: CH_W], bright_q);
                data_d[B_LSB +: CH_W] = scale_ch(rd_data_p1[B_LSB +: CH_W], bright_q);
                vld_d   = 1'b1;
                state_d = SEND;
            end
            SEND: if (pix.pix_ready) begin
                vld_d = 1'b0;
                if (idx_q == LAST_IDX) begin
                    state_d = DRAIN;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = LOAD;
                end
            end
            DRAIN: if (pix.tx_idle) begin
                gap_d   = '0;
                state_d = LATCH;
            end
            LATCH: if (gap_q == 32'(RESET_CYCLES - 1)) begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end else begin
                gap_d = gap_q + 32'd1;
            end
            default: state_d = IDLE;
        endcase
        // Requests arriving outside IDLE (including the last latch cycle) are remembered once.
        if (state_q != IDLE && start_req)
            pending_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            vld_q     <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            vld_q     <= vld_d;
            data_q    <= data_d;
        end
    end

    always_ff @(posedge clk) begin
        idx_q    <= idx_d;
        bright_q <= bright_d;
        gap_q    <= gap_d;
    end

    assign busy          = busy_q;
    assign frame_done    = done_q;
    assign pix.pix_valid = vld_q;
    assign pix.pix_data  = data_q;

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Directed bench for ws2812_frame_ctrl: frame streaming, scaling, stall, pending, reset and auto-refresh.
module tb_ws2812_frame_ctrl;
    import ws2812_pkg::*;

    localparam int N   = 3;
    localparam int CLK = 1_000_000;
    localparam int RUS = 60;
    localparam int RC  = 60;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [23:0] wr_data;
    logic [7:0]  bright;
    logic        frame_req;
    logic        busy, frame_done;
    logic        busy_b, done_b;

    int nvec = 0;
    int nmiss = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    ws2812_frame_ctrl_if pa ();
    ws2812_frame_ctrl_if pb ();

    ws2812_frame_ctrl #(.NUM_LEDS(N), .CLK_FRE(CLK), .RESET_US(RUS), .REFRESH_HZ(0)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .bright(bright), .frame_req(frame_req), .busy(busy), .frame_done(frame_done), .pix(pa)
    );

    ws2812_frame_ctrl #(.NUM_LEDS(N), .CLK_FRE(CLK), .RESET_US(RUS), .REFRESH_HZ(1000)) dut_rf (
        .clk(clk), .rst(rst), .wr_en(1'b0), .wr_addr(2'd0), .wr_data(24'd0),
        .bright(8'd255), .frame_req(1'b0), .busy(busy_b), .frame_done(done_b), .pix(pb)
    );

    assign pb.pix_ready = 1'b1;
    assign pb.tx_idle   = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmiss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic write_pix(input logic [1:0] a, input logic [23:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic start_frame();
        frame_req = 1'b1;
        step();
        frame_req = 1'b0;
    endtask

    // Waits for the next offered pixel, checks it, and lets the handshake happen.
    task automatic get_pix(input string tag, input logic [23:0] exp);
        int n = 0;
        while (!pa.pix_valid && n < 100) begin step(); n++; end
        if (!pa.pix_valid) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        check(tag, {8'd0, pa.pix_data}, {8'd0, exp});
        step();
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!frame_done && n < 300) begin step(); n++; end
        if (!frame_done) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_done_b(output int t);
        int n = 0;
        while (!done_b && n < 3000) begin step(); n++; end
        if (!done_b) check("refresh_timeout", 32'd0, 32'd1);
        t = cyc;
        step();
    endtask

    initial begin
        int n;
        int t0, t1, t2;
        logic stable;

        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        bright = 8'd255; frame_req = 1'b0;
        pa.pix_ready = 1'b1; pa.tx_idle = 1'b0;
        repeat (3) step();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, frame_done}, 32'd0);
        check("rst_valid", {31'd0, pa.pix_valid}, 32'd0);
        check("rst_data", {8'd0, pa.pix_data}, 32'd0);
        rst = 1'b0;

        write_pix(2'd0, 24'hFF0000);
        write_pix(2'd1, 24'h00FF00);
        write_pix(2'd2, 24'h0000FF);

        start_frame();
        check("lat_busy", {31'd0, busy}, 32'd1);
        check("lat_v1", {31'd0, pa.pix_valid}, 32'd0);
        step();
        check("lat_v2", {31'd0, pa.pix_valid}, 32'd0);
        step();
        check("lat_v3", {31'd0, pa.pix_valid}, 32'd1);
        get_pix("f1_p0", 24'hFF0000);
        check("f1_busy0", {31'd0, busy}, 32'd1);
        get_pix("f1_p1", 24'h00FF00);
        get_pix("f1_p2", 24'h0000FF);
        repeat (5) step();
        check("drain_busy", {31'd0, busy}, 32'd1);
        check("drain_done", {31'd0, frame_done}, 32'd0);

        // One cycle to register tx_idle in DRAIN, then RC latch cycles.
        pa.tx_idle = 1'b1;
        n = 0;
        while (!frame_done && n < 200) begin step(); n++; end
        check("gap_len", n, RC + 1);
        check("gap_busy", {31'd0, busy}, 32'd0);
        step();
        check("done_pulse", {31'd0, frame_done}, 32'd0);

        write_pix(2'd0, 24'h804020);
        bright = 8'd127;
        start_frame();
        bright = 8'd0;
        get_pix("b127_p0", 24'h402010);
        get_pix("b127_p1", 24'h007F00);
        get_pix("b127_p2", 24'h00007F);
        wait_done("b127");
        step();

        write_pix(2'd0, 24'hFFFFFF);
        start_frame();
        get_pix("b0_p0", 24'h000000);
        get_pix("b0_p1", 24'h000000);
        get_pix("b0_p2", 24'h000000);
        wait_done("b0");
        step();

        bright = 8'd255;
        pa.pix_ready = 1'b0;
        start_frame();
        for (int k = 0; k < 3; k++) begin
            step();
            frame_req = 1'b1;
            step();
            frame_req = 1'b0;
        end
        write_pix(2'd0, 24'hABCDEF);
        write_pix(2'd2, 24'h123456);
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (pa.pix_valid !== 1'b1 || pa.pix_data !== 24'hFFFFFF) stable = 1'b0;
            step();
        end
        check("stall_stable", {31'd0, stable}, 32'd1);
        pa.pix_ready = 1'b1;
        get_pix("pend_a_p0", 24'hFFFFFF);
        get_pix("pend_a_p1", 24'h00FF00);
        get_pix("pend_a_p2", 24'h123456);
        wait_done("pend_a");
        check("pend_gap_busy", {31'd0, busy}, 32'd0);
        step();
        check("pend_restart_busy", {31'd0, busy}, 32'd1);
        get_pix("pend_b_p0", 24'hABCDEF);
        get_pix("pend_b_p1", 24'h00FF00);
        get_pix("pend_b_p2", 24'h123456);
        wait_done("pend_b");
        repeat (5) step();
        check("no_third_frame", {31'd0, busy}, 32'd0);

        start_frame();
        get_pix("rst_mid_p0", 24'hABCDEF);
        pa.pix_ready = 1'b0;
        n = 0;
        while (!pa.pix_valid && n < 20) begin step(); n++; end
        check("rst_mid_p1", {8'd0, pa.pix_data}, 32'h0000FF00);
        rst = 1'b1;
        step();
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_valid", {31'd0, pa.pix_valid}, 32'd0);
        rst = 1'b0;
        pa.pix_ready = 1'b1;
        start_frame();
        get_pix("restart_p0", 24'hABCDEF);
        get_pix("restart_p1", 24'h00FF00);
        get_pix("restart_p2", 24'h123456);
        wait_done("restart");

        wait_done_b(t0);
        wait_done_b(t1);
        wait_done_b(t2);
        check("refresh_int1", t1 - t0, 32'd1000);
        check("refresh_int2", t2 - t1, 32'd1000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
        $finish;
    end

endmodule
